// File: rtl/distance_job_dispatcher_pkg.sv
// Shared state encoding, default widths and watchdog limit for the distance job dispatcher.
package dispatcher_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int RES_W_DEF   = 32;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_CLR  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/distance_job_dispatcher_if.sv
// Operand-in, control-unit and result-out signals of the dispatcher, bundled with
// a slave view for the dispatcher and a master view for whoever drives it.
interface distance_job_dispatcher_if
  import dispatcher_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) ();

  localparam int LVL_W = level_width(DEPTH);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic              s;
  logic [DATA_W-1:0] x_out;
  logic              done;
  logic [RES_W-1:0]  result_in;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_result;
  logic              busy;
  logic              err;
  logic [LVL_W-1:0]  level;

  modport slave (
    input  in_valid, in_x, done, result_in, out_ready,
    output in_ready, s, x_out, out_valid, out_result, busy, err, level
  );

  modport master (
    output in_valid, in_x, done, result_in, out_ready,
    input  in_ready, s, x_out, out_valid, out_result, busy, err, level
  );

endinterface

// File: rtl/distance_job_dispatcher_job_fifo.sv
// Operand FIFO: pointers carry an extra wrap bit so full and empty are distinguishable
// without a counter; the occupancy is kept in its own register so it leaves as a flop.
module job_fifo
  import dispatcher_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             din_i,
  input  logic                          pop_i,
  output logic [DATA_W-1:0]             dout_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [level_width(DEPTH)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     level_q,  level_d;
  logic              do_push_s;
  logic              do_pop_s;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign dout_o    = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o   = level_q;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + PTR_ONE;
      2'b01:   level_d = level_q - PTR_ONE;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      level_q  <= PTR_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/distance_job_dispatcher.sv
// Dispatcher top: queues operands, launches one control-unit job per operand, collects the
// distance result behind a valid/ready output and aborts jobs that overrun the watchdog.
module distance_job_dispatcher
  import dispatcher_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  distance_job_dispatcher_if.slave  bus
);

  localparam int LW   = level_width(DEPTH);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_ZERO = {WD_W{1'b0}};
  localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q,    wd_d;
  logic [DATA_W-1:0] x_q,     x_d;
  logic [RES_W-1:0]  res_q,   res_d;
  logic              s_q,     s_d;
  logic              err_q,   err_d;
  logic              ov_q,    ov_d;

  logic              push_s;
  logic              pop_s;
  logic              capture_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [DATA_W-1:0] fifo_dout_s;
  logic [LW-1:0]     fifo_level_s;

  assign push_s = bus.in_valid && !fifo_full_s;

  job_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_job_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push_s),
    .din_i   (bus.in_x),
    .pop_i   (pop_s),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level_s)
  );

  // Job sequencing and watchdog; a done held high behind a full output is a stall, not time spent.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    x_d       = x_q;
    s_d       = 1'b0;
    err_d     = 1'b0;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          x_d     = fifo_dout_s;
          s_d     = 1'b1;
          state_d = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        wd_d    = WD_ZERO;
        state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          wd_d    = WD_ZERO;
          state_d = IDLE;
        end else if (!bus.done) begin
          wd_d    = wd_q + WD_ONE;
          state_d = WAIT_DONE;
        end else begin
          wd_d    = wd_q + WD_ONE;
        end
      end
      WAIT_DONE: begin
        if (bus.done && (!ov_q || bus.out_ready)) begin
          capture_s = 1'b1;
          wd_d      = WD_ZERO;
          state_d   = IDLE;
        end else if (bus.done) begin
          wd_d      = wd_q;
        end else if (wd_q == WD_LAST) begin
          err_d     = 1'b1;
          wd_d      = WD_ZERO;
          state_d   = IDLE;
        end else begin
          wd_d      = wd_q + WD_ONE;
        end
      end
      default: begin
        wd_d    = WD_ZERO;
        state_d = IDLE;
      end
    endcase
  end

  // Result register: a fresh capture wins over the consumer draining the old one.
  always_comb begin
    ov_d  = ov_q;
    res_d = res_q;
    if (capture_s) begin
      ov_d  = 1'b1;
      res_d = bus.result_in;
    end else if (ov_q && bus.out_ready) begin
      ov_d  = 1'b0;
    end else begin
      ov_d  = ov_q;
    end
  end

  // State, watchdog and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wd_q    <= WD_ZERO;
      x_q     <= {DATA_W{1'b0}};
      res_q   <= {RES_W{1'b0}};
      s_q     <= 1'b0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      x_q     <= x_d;
      res_q   <= res_d;
      s_q     <= s_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready   = !fifo_full_s;
  assign bus.busy       = (state_q != IDLE);
  assign bus.s          = s_q;
  assign bus.x_out      = x_q;
  assign bus.out_valid  = ov_q;
  assign bus.out_result = res_q;
  assign bus.err        = err_q;
  assign bus.level      = fifo_level_s;

endmodule

// File: tb/tb_distance_job_dispatcher.sv
// Directed bench for distance_job_dispatcher with a behavioural control-unit model.
module tb_distance_job_dispatcher;

  localparam int DW = 16;
  localparam int RW = 32;
  localparam int DP = 4;
  localparam int TO = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  distance_job_dispatcher_if #(.DATA_W(DW), .RES_W(RW), .DEPTH(DP)) dif ();

  distance_job_dispatcher #(.DATA_W(DW), .RES_W(RW), .DEPTH(DP), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  typedef struct {
    logic [15:0] x;
    logic [31:0] res;
    int          lat;
  } job_vec_t;

  job_vec_t    vecs [4];
  logic [15:0] fillq [5];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic        cu_hang   = 1'b0;
  logic        cu_use_fn = 1'b0;
  logic        cu_drop   = 1'b0;
  int          cu_lat    = 1;
  int          cu_cnt    = 0;
  logic [31:0] cu_res    = 32'h0;
  logic [31:0] cu_res_q  = 32'h0;

  int   s_cnt, s_at, ov_at, xbad, bad, errs, idx, err_at, rdy_seen, ov_seen, n_s, n_r, sbad;
  logic found, push_now;

  function automatic logic [31:0] fn(input logic [15:0] x);
    return {~x, x};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: wait for the falling edge, then advance the control-unit model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cu_drop) begin
      dif.done      = 1'b0;
      dif.result_in = 32'hBAD0_BAD0;
      cu_drop       = 1'b0;
      cu_cnt        = cu_lat;
    end else if (cu_cnt > 0) begin
      cu_cnt--;
      if (cu_cnt == 0) begin
        dif.done      = 1'b1;
        dif.result_in = cu_res_q;
      end
    end
    if (dif.s === 1'b1 && !cu_hang) begin
      cu_drop  = 1'b1;
      cu_res_q = cu_use_fn ? fn(dif.x_out) : cu_res;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},   dif.in_ready,   1);
    check({tag, "_s"},          dif.s,          0);
    check({tag, "_x_out"},      dif.x_out,      0);
    check({tag, "_out_valid"},  dif.out_valid,  0);
    check({tag, "_out_result"}, dif.out_result, 0);
    check({tag, "_busy"},       dif.busy,       0);
    check({tag, "_err"},        dif.err,        0);
    check({tag, "_level"},      dif.level,      0);
  endtask

  initial begin
    vecs[0] = '{x: 16'h0005, res: 32'h0000_1234, lat: 10};
    vecs[1] = '{x: 16'hFFFF, res: 32'hFFFF_FFFF, lat: 1};
    vecs[2] = '{x: 16'h0000, res: 32'h0000_0000, lat: 3};
    vecs[3] = '{x: 16'h8001, res: 32'hDEAD_BEEF, lat: 5};
    fillq[0] = 16'h0101; fillq[1] = 16'h0202; fillq[2] = 16'h0303;
    fillq[3] = 16'h0404; fillq[4] = 16'h0505;

    reset         = 1'b0;
    dif.in_valid  = 1'b0;
    dif.in_x      = 16'h0;
    dif.done      = 1'b1;
    dif.result_in = 32'h0;
    dif.out_ready = 1'b1;
    tick(); tick(); tick();
    check_reset_vals("por");
    reset = 1'b1;
    tick();

    // Single jobs from the vector table.
    for (int i = 0; i < 4; i++) begin
      cu_use_fn = 1'b0; cu_res = vecs[i].res; cu_lat = vecs[i].lat;
      dif.in_valid = 1'b1; dif.in_x = vecs[i].x;
      tick();
      dif.in_valid = 1'b0;
      check("job_level_after_push", dif.level, 1);
      s_cnt = 0; s_at = -1; ov_at = -1; xbad = 0;
      for (int c = 0; c < 64; c++) begin
        if (dif.s) begin s_cnt++; s_at = c; end
        if (dif.busy && dif.x_out !== vecs[i].x) xbad++;
        if (dif.out_valid) begin ov_at = c; break; end
        tick();
      end
      check("job_s_count",     s_cnt, 1);
      check("job_s_timing",    s_at, 1);
      check("job_out_latency", ov_at, 3 + vecs[i].lat);
      check("job_out_result",  dif.out_result, vecs[i].res);
      check("job_x_out_hold",  xbad, 0);
      check("job_x_out_final", dif.x_out, vecs[i].x);
      tick();
      check("job_out_valid_one_cycle", dif.out_valid, 0);
      check("job_idle_after", dif.busy, 0);
    end

    // Output backpressure across two completed jobs, held longer than the watchdog.
    cu_use_fn = 1'b1; cu_lat = 2; dif.out_ready = 1'b0;
    dif.in_valid = 1'b1; dif.in_x = 16'h0011; tick();
    dif.in_x = 16'h0022; tick();
    dif.in_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (dif.out_valid) break;
      tick();
    end
    check("bp_first_valid",  dif.out_valid, 1);
    check("bp_first_result", dif.out_result, fn(16'h0011));
    bad = 0; errs = 0;
    for (int c = 0; c < 300; c++) begin
      if (!dif.out_valid || dif.out_result !== fn(16'h0011)) bad++;
      if (dif.err) errs++;
      tick();
    end
    check("bp_first_held",  bad, 0);
    check("bp_no_err",      errs, 0);
    check("bp_fsm_stalled", dif.busy, 1);
    dif.out_ready = 1'b1;
    tick();
    check("bp_second_valid",  dif.out_valid, 1);
    check("bp_second_result", dif.out_result, fn(16'h0022));
    check("bp_second_idle",   dif.busy, 0);
    tick();
    check("bp_drained", dif.out_valid, 0);

    // Fill behind a hung job, then watchdog abort and in-order drain.
    cu_hang = 1'b1; cu_lat = 3;
    dif.in_valid = 1'b1; dif.in_x = 16'h0AAA; tick();
    dif.in_valid = 1'b0;
    s_at = -1;
    for (int c = 0; c < 10; c++) begin
      if (dif.s) begin s_at = cyc; break; end
      tick();
    end
    check("wd_launch_seen", (s_at >= 0), 1);
    idx = 0; dif.in_valid = 1'b1; dif.in_x = fillq[0];
    for (int c = 0; c < 8; c++) begin
      if (dif.in_ready) idx++;
      tick();
      if (idx < 5) dif.in_x = fillq[idx];
    end
    check("fill_accepted",     idx, 4);
    check("fill_level",        dif.level, 4);
    check("fill_in_ready_low", dif.in_ready, 0);
    err_at = -1; rdy_seen = 0; ov_seen = 0;
    for (int c = 0; c < 400; c++) begin
      if (dif.err) begin err_at = cyc; break; end
      if (dif.in_ready) rdy_seen++;
      if (dif.out_valid) ov_seen++;
      tick();
    end
    cu_hang = 1'b0;
    check("wd_err_delay",     err_at - s_at, TO + 1);
    check("wd_fifo_held",     rdy_seen, 0);
    check("wd_no_out_valid",  ov_seen, 0);
    check("wd_level_at_err",  dif.level, 4);
    tick();
    check("wd_err_one_cycle", dif.err, 0);
    n_s = 0; n_r = 0; errs = 0;
    for (int c = 0; c < 300 && n_r < 5; c++) begin
      push_now = dif.in_valid && dif.in_ready;
      if (dif.s) begin
        if (n_s < 5) check("order_x_out", dif.x_out, fillq[n_s]);
        n_s++;
      end
      if (dif.out_valid) begin
        if (n_r < 5) check("order_result", dif.out_result, fn(fillq[n_r]));
        n_r++;
      end
      if (dif.err) errs++;
      tick();
      if (push_now) dif.in_valid = 1'b0;
    end
    check("order_launches", n_s, 5);
    check("order_results",  n_r, 5);
    check("order_no_err",   errs, 0);

    // Simultaneous push and pop while idle at level 2.
    cu_lat = 6;
    dif.in_valid = 1'b1; dif.in_x = 16'h00A1; tick();
    dif.in_x = 16'h00B2; tick();
    dif.in_x = 16'h00C3; tick();
    dif.in_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (!dif.busy && dif.level == 2) begin found = 1'b1; break; end
      tick();
    end
    check("pp_idle_at_level2", found, 1);
    dif.in_valid = 1'b1; dif.in_x = 16'h00D4; tick();
    dif.in_valid = 1'b0;
    check("pp_level_kept",  dif.level, 2);
    check("pp_in_ready",    dif.in_ready, 1);
    check("pp_popped_x",    dif.x_out, 16'h00B2);
    check("pp_launched",    dif.busy, 1);

    // Reset during WAIT_DONE with three entries queued.
    dif.in_valid = 1'b1; dif.in_x = 16'h00E5; tick();
    dif.in_valid = 1'b0;
    tick(); tick(); tick();
    check("rst_pre_busy",  dif.busy, 1);
    check("rst_pre_level", dif.level, 3);
    reset = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    cu_drop = 1'b0; cu_cnt = 0; dif.done = 1'b1;
    tick(); tick();
    reset = 1'b1;
    sbad = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (dif.s) sbad++;
      if (dif.level != 0 || dif.busy || dif.out_valid) bad++;
      tick();
    end
    check("rst_no_s_after", sbad, 0);
    check("rst_stays_idle", bad, 0);
    check("rst_level_zero", dif.level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
